// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (processor / DMA) arbiter for a shared memory
// controller bus. Grants are registered and mutually exclusive; the memory
// bus is muxed combinationally from whichever channel currently holds a
// grant and is still requesting.
//
// Build option: define MEM_ARBITER_FAIR_EN to cap DMA bursts at MAX_BURST
// cycles and hand the processor one slot when it is waiting. Without the
// macro DMA has strict priority and bursts are unbounded.
module mem_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc_req,
    input  logic [15:0] proc_addr,
    input  logic        proc_write,
    input  logic [15:0] proc_wdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_write,
    input  logic [15:0] dma_wdata,
    output logic        proc_gnt,
    output logic        dma_gnt,
    output logic        proc_en,
    output logic [15:0] memaddr,
    output logic        memwrite,
    output logic [15:0] writedata,
    output logic [7:0]  burst_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DMA  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Reject an out-of-range burst limit at elaboration time.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("mem_arbiter: MAX_BURST must be in 1..255");
    end

`ifdef MEM_ARBITER_FAIR_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
`endif

    // Next-state decision; DMA wins ties, fair mode may force a PROC slot.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps any path that
        // forgets to assign it from inferring a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (dma_req)       next_state = DMA;
                else if (proc_req) next_state = PROC;
                else               next_state = IDLE;
            end
            PROC: begin
                if (dma_req)        next_state = DMA;
                else if (!proc_req) next_state = IDLE;
                else                next_state = PROC;
            end
            DMA: begin
                if (!dma_req) next_state = proc_req ? PROC : IDLE;
                else          next_state = DMA;
`ifdef MEM_ARBITER_FAIR_EN
                // Once the burst limit is reached, a waiting processor gets
                // one slot; '>=' also catches a processor that arrives after
                // the count has run past the limit.
                if (proc_req && burst_cnt >= BURST_LIMIT) next_state = PROC;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // State register with registered grants and DMA burst counter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            proc_gnt  <= 1'b0;
            dma_gnt   <= 1'b0;
            burst_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            proc_gnt <= (next_state == PROC);
            dma_gnt  <= (next_state == DMA);
            if (next_state == DMA)
                burst_cnt <= (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
            else
                burst_cnt <= 8'd0;
        end
    end

    assign proc_en = proc_gnt;

    // Memory bus follows the granted channel only while it still requests;
    // a requester without a grant can never reach memwrite.
    always_comb begin
        memaddr   = 16'h0000;
        writedata = 16'h0000;
        memwrite  = 1'b0;
        if (proc_gnt && proc_req) begin
            memaddr   = proc_addr;
            writedata = proc_wdata;
            memwrite  = proc_write;
        end else if (dma_gnt && dma_req) begin
            memaddr   = dma_addr;
            writedata = dma_wdata;
            memwrite  = dma_write;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Covers reset, processor and DMA
// writes, preemption, burst behaviour (fair or strict build, selected by
// MEM_ARBITER_FAIR_EN) and reset asserted in the middle of a DMA burst.
module tb_mem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_req, proc_write, dma_req, dma_write;
    logic [15:0] proc_addr, proc_wdata, dma_addr, dma_wdata;
    logic        proc_gnt, dma_gnt, proc_en, memwrite;
    logic [15:0] memaddr, writedata;
    logic [7:0]  burst_cnt;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_req   (proc_req),
        .proc_addr  (proc_addr),
        .proc_write (proc_write),
        .proc_wdata (proc_wdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_write  (dma_write),
        .dma_wdata  (dma_wdata),
        .proc_gnt   (proc_gnt),
        .dma_gnt    (dma_gnt),
        .proc_en    (proc_en),
        .memaddr    (memaddr),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .burst_cnt  (burst_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        proc_req = 1'b0;
        dma_req  = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        proc_req = 1'b1; proc_write = 1'b1; proc_addr = 16'h1111; proc_wdata = 16'h2222;
        dma_req  = 1'b1; dma_write  = 1'b1; dma_addr  = 16'h3333; dma_wdata  = 16'h4444;
        step();
        step();
        checks++;
        if ({proc_gnt, dma_gnt, proc_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_grants: got proc_gnt/dma_gnt/proc_en=%b%b%b want 000", proc_gnt, dma_gnt, proc_en);
        end
        checks++;
        if (memwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_memwrite: got %b want 0", memwrite);
        end
        checks++;
        if (burst_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_burst: got %0d want 0", burst_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({dma_gnt, proc_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_dma: got dma_gnt/proc_gnt=%b%b want 10", dma_gnt, proc_gnt);
        end
        go_idle();
        checks++;
        if ({dma_gnt, proc_gnt, memwrite} !== 3'b000) begin
            errors++;
            $display("FAIL idle_state: got dma_gnt/proc_gnt/memwrite=%b%b%b want 000", dma_gnt, proc_gnt, memwrite);
        end
    endtask

    task automatic test_simple_write();
        proc_req = 1'b1; proc_write = 1'b1; proc_addr = 16'h1234; proc_wdata = 16'hBEEF;
        #1;
        checks++;
        if ({memwrite, memaddr} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL write_before_grant: got memwrite=%b memaddr=%h want 0/0000", memwrite, memaddr);
        end
        step();
        checks++;
        if ({proc_gnt, proc_en, dma_gnt} !== 3'b110) begin
            errors++;
            $display("FAIL write_grant: got proc_gnt/proc_en/dma_gnt=%b%b%b want 110", proc_gnt, proc_en, dma_gnt);
        end
        checks++;
        if ({memaddr, writedata, memwrite} !== {16'h1234, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL write_bus: got addr=%h data=%h we=%b want 1234/beef/1", memaddr, writedata, memwrite);
        end
        proc_req = 1'b0;
        #1;
        checks++;
        if ({memaddr, writedata, memwrite} !== 33'd0) begin
            errors++;
            $display("FAIL write_req_dropped: got addr=%h data=%h we=%b want 0/0/0", memaddr, writedata, memwrite);
        end
        go_idle();
    endtask

    task automatic test_preempt();
        proc_req = 1'b1; proc_write = 1'b1; proc_addr = 16'h0F0F; proc_wdata = 16'hAAAA;
        step();
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h00A0; dma_wdata = 16'h5A5A;
        step();
        checks++;
        if ({dma_gnt, proc_gnt, proc_en} !== 3'b100) begin
            errors++;
            $display("FAIL preempt_grant: got dma_gnt/proc_gnt/proc_en=%b%b%b want 100", dma_gnt, proc_gnt, proc_en);
        end
        checks++;
        if ({memwrite, memaddr} !== {1'b0, 16'h00A0}) begin
            errors++;
            $display("FAIL preempt_bus: got memwrite=%b memaddr=%h want 0/00a0", memwrite, memaddr);
        end
        checks++;
        if (burst_cnt !== 8'd1) begin
            errors++;
            $display("FAIL preempt_burst: got %0d want 1", burst_cnt);
        end
        dma_req = 1'b0;
        step();
        checks++;
        if ({proc_gnt, dma_gnt, burst_cnt} !== {2'b10, 8'd0}) begin
            errors++;
            $display("FAIL return_to_proc: got proc_gnt=%b dma_gnt=%b burst=%0d want 1/0/0", proc_gnt, dma_gnt, burst_cnt);
        end
        go_idle();
    endtask

    task automatic test_dma_write();
        proc_write = 1'b0;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h5555; dma_wdata = 16'h1234;
        step();
        checks++;
        if ({memaddr, writedata, memwrite} !== {16'h5555, 16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL dma_write_bus: got addr=%h data=%h we=%b want 5555/1234/1", memaddr, writedata, memwrite);
        end
        dma_req = 1'b0;
        #1;
        checks++;
        if ({memaddr, writedata, memwrite} !== 33'd0) begin
            errors++;
            $display("FAIL dma_req_dropped: got addr=%h data=%h we=%b want 0/0/0", memaddr, writedata, memwrite);
        end
        go_idle();
    endtask

`ifdef MEM_ARBITER_FAIR_EN
    // Both held: DMA for MAX_BURST cycles (count 1..4), one PROC slot (count 0).
    task automatic test_burst();
        logic exp_dma;
        logic [7:0] exp_cnt;
        proc_req = 1'b1; dma_req = 1'b1; dma_write = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            exp_dma = ((k % 5) != 4);
            exp_cnt = exp_dma ? 8'((k % 5) + 1) : 8'd0;
            checks++;
            if ({dma_gnt, proc_gnt, burst_cnt} !== {exp_dma, ~exp_dma, exp_cnt}) begin
                errors++;
                $display("FAIL fair_cycle_%0d: got dma_gnt=%b proc_gnt=%b burst=%0d want %b/%b/%0d",
                         k, dma_gnt, proc_gnt, burst_cnt, exp_dma, ~exp_dma, exp_cnt);
            end
        end
        go_idle();
    endtask
`else
    // Both held: DMA keeps the bus; count climbs and saturates at 255.
    task automatic test_burst();
        logic [7:0] exp_cnt;
        proc_req = 1'b1; dma_req = 1'b1; dma_write = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            exp_cnt = (k >= 254) ? 8'd255 : 8'(k + 1);
            checks++;
            if ({dma_gnt, proc_gnt, burst_cnt} !== {2'b10, exp_cnt}) begin
                errors++;
                $display("FAIL strict_cycle_%0d: got dma_gnt=%b proc_gnt=%b burst=%0d want 1/0/%0d",
                         k, dma_gnt, proc_gnt, burst_cnt, exp_cnt);
            end
        end
        go_idle();
    endtask
`endif

    task automatic test_midburst_reset();
        proc_req = 1'b0;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0707; dma_wdata = 16'h7777;
        for (int k = 0; k < 7; k++) step();
        checks++;
        if ({dma_gnt, burst_cnt, memwrite} !== {1'b1, 8'd7, 1'b1}) begin
            errors++;
            $display("FAIL midburst_setup: got dma_gnt=%b burst=%0d we=%b want 1/7/1", dma_gnt, burst_cnt, memwrite);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dma_gnt, burst_cnt, memwrite} !== {1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL midburst_async: got dma_gnt=%b burst=%0d we=%b want 0/0/0", dma_gnt, burst_cnt, memwrite);
        end
        proc_req = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({dma_gnt, proc_gnt, burst_cnt} !== {2'b10, 8'd1}) begin
            errors++;
            $display("FAIL midburst_rearb: got dma_gnt=%b proc_gnt=%b burst=%0d want 1/0/1", dma_gnt, proc_gnt, burst_cnt);
        end
        go_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simple_write();
        test_preempt();
        test_dma_write();
        test_burst();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
